// File: rtl/mem_arbiter.sv
// Purpose : round-robin share of one single-port word memory between fetch (f_*) and load/store (d_*).
// Latency : grant in the request cycle when idle; reads and full writes done at T+1, byte-masked writes at T+2.
// Backpressure: one access in flight; requests wait (req held) until a grant, grants only given from IDLE.
// Ports   : clock/reset_n (sync, active-low); f_req/f_addr -> f_gnt/f_done/f_rdata;
//           d_req/d_we/d_be/d_addr/d_wdata -> d_gnt/d_done/d_rdata;
//           mem_write_en/mem_read_en/mem_address/mem_data_i -> memory, mem_data_o <- memory (1-cycle read).
module mem_arbiter #(
  parameter int WORDSIZE = 4,
  parameter int MEMSIZE  = 32 * 1024,
  localparam int ADDR_W  = $clog2(MEMSIZE),
  localparam int DW      = WORDSIZE * 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  output logic [DW-1:0]     f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORDSIZE-1:0] d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DW-1:0]     d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DW-1:0]     d_rdata,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DW-1:0]     mem_data_i,
  input  logic [DW-1:0]     mem_data_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WR  = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                last_gnt;
  logic                cur_port;
  logic [ADDR_W-1:0]   lat_addr;
  logic [WORDSIZE-1:0] lat_be;
  logic [DW-1:0]       lat_wdata;
  logic [DW-1:0]       merged;
  logic                pick_d;
  logic                pick_f;

  // Data wins unless fetch also asks and data had the previous grant.
  assign pick_d = d_req & (~f_req | (last_gnt == FETCH));
  assign pick_f = f_req & ~pick_d;

  // Old word arrives from the read issued in the grant cycle; overlay enabled bytes.
  always_comb begin
    merged = '0;
    for (int i = 0; i < WORDSIZE; i++) begin
      merged[i*8 +: 8] = lat_be[i] ? lat_wdata[i*8 +: 8] : mem_data_o[i*8 +: 8];
    end
  end

  // All outputs are forced to 0 while reset_n is low, which also blocks an
  // in-progress read-modify-write from reaching the memory.
  always_comb begin
    state_nxt    = state;
    f_gnt        = 1'b0;
    f_done       = 1'b0;
    f_rdata      = '0;
    d_gnt        = 1'b0;
    d_done       = 1'b0;
    d_rdata      = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    mem_address  = '0;
    mem_data_i   = '0;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            d_gnt = 1'b1;
            if (!d_we) begin
              mem_read_en = 1'b1;
              mem_address = d_addr;
              state_nxt   = RD_WAIT;
            end else if (&d_be) begin
              mem_write_en = 1'b1;
              mem_address  = d_addr;
              mem_data_i   = d_wdata;
              state_nxt    = ACK;
            end else if (d_be == '0) begin
              state_nxt = ACK;
            end else begin
              mem_read_en = 1'b1;
              mem_address = d_addr;
              state_nxt   = RMW_WR;
            end
          end else if (pick_f) begin
            f_gnt       = 1'b1;
            mem_read_en = 1'b1;
            mem_address = f_addr;
            state_nxt   = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cur_port == DATA) begin
            d_done  = 1'b1;
            d_rdata = mem_data_o;
          end else begin
            f_done  = 1'b1;
            f_rdata = mem_data_o;
          end
          state_nxt = IDLE;
        end
        RMW_WR: begin
          mem_write_en = 1'b1;
          mem_address  = lat_addr;
          mem_data_i   = merged;
          state_nxt    = ACK;
        end
        default: begin
          d_done    = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_gnt  <= FETCH;
      cur_port  <= FETCH;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (f_gnt) begin
        last_gnt <= FETCH;
        cur_port <= FETCH;
      end else if (d_gnt) begin
        last_gnt  <= DATA;
        cur_port  <= DATA;
        lat_addr  <= d_addr;
        lat_be    <= d_be;
        lat_wdata <= d_wdata;
      end
    end
  end

endmodule
